pipe_stall_ctrl: RTL and testbench

Central stall sequencer for the five-stage MIPS pipeline. It merges three stall sources into the single `stall` bus that every stage register consumes:

- ID load-use hazard.
- EX multi-cycle divide.
- Data-SRAM wait.

It also issues the divider start pulse, bounds divide latency with a timeout, and optionally counts stall cycles per cause.

---
 rtl/pipe_stall_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stall_ctrl: merges load-use, divide and data-SRAM stalls into one   |
// | stage stop vector, sequences the divider and bounds its latency.         |
// | Optional macro: PIPE_PERF_CNT_EN builds the per-cause stall counters.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_stall_ctrl #(
  parameter int STALL_W     = 6,
  parameter int CNT_W       = 32,
  parameter int DIV_MAX_CYC = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_for_load,
  input  logic               ex_div_req,
  input  logic               div_ready,
  input  logic               mem_wait,
  output logic [STALL_W-1:0] stall,
  output logic               div_start,
  output logic               div_busy,
  output logic               div_timeout,
  output logic [CNT_W-1:0]   load_stall_cnt,
  output logic [CNT_W-1:0]   div_stall_cnt,
  output logic [CNT_W-1:0]   mem_stall_cnt
);

  localparam int c_DIV_CNT_W = (DIV_MAX_CYC > 2) ? $clog2(DIV_MAX_CYC) : 1;
  localparam logic [c_DIV_CNT_W-1:0] c_DIV_LAST = c_DIV_CNT_W'(DIV_MAX_CYC - 1);
  localparam logic [STALL_W-1:0] c_STALL_MEM  = STALL_W'(6'b011111);
  localparam logic [STALL_W-1:0] c_STALL_DIV  = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] c_STALL_LOAD = STALL_W'(6'b000111);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_LOAD_BUBBLE = 2'd1,
    ST_DIV_WAIT    = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  state_t                   w_state_eff;
  logic [c_DIV_CNT_W-1:0]   r_div_cnt;
  logic [c_DIV_CNT_W-1:0]   w_div_cnt_nxt;
  logic                     r_div_done;
  logic                     w_div_done_nxt;
  logic                     r_div_start;
  logic                     w_div_start_nxt;
  logic                     r_div_timeout;
  logic                     w_div_timeout_nxt;
  logic                     w_idle;
  logic                     w_div_wait;
  logic                     w_div_hit;
  logic                     w_div_expire;
  logic                     w_div_release;
  logic                     w_cause_mem;
  logic                     w_cause_div;
  logic                     w_cause_load;
  logic [STALL_W-1:0]       w_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_div_cnt     <= '0;
      r_div_done    <= 1'b0;
      r_div_start   <= 1'b0;
      r_div_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_div_cnt     <= w_div_cnt_nxt;
      r_div_done    <= w_div_done_nxt;
      r_div_start   <= w_div_start_nxt;
      r_div_timeout <= w_div_timeout_nxt;
    end
  end

  always_comb begin
    // While reset is asserted the stall vector behaves as if already in IDLE.
    w_state_eff   = rst ? r_state : ST_IDLE;
    w_idle        = (w_state_eff == ST_IDLE);
    w_div_wait    = (w_state_eff == ST_DIV_WAIT);
    w_div_hit     = w_div_wait && (div_ready || r_div_done);
    w_div_expire  = w_div_wait && !w_div_hit && (r_div_cnt == c_DIV_LAST);
    w_div_release = w_div_hit || w_div_expire;

    w_cause_mem  = mem_wait;
    w_cause_div  = !mem_wait &&
                   ((w_div_wait && !w_div_release) || (w_idle && ex_div_req));
    w_cause_load = !mem_wait && !w_cause_div && w_idle && stallreq_for_load;

    w_stall = '0;
    if (w_cause_mem) begin
      w_stall = c_STALL_MEM;
    end else if (w_cause_div) begin
      w_stall = c_STALL_DIV;
    end else if (w_cause_load) begin
      w_stall = c_STALL_LOAD;
    end

    w_state_nxt       = w_state_eff;
    w_div_cnt_nxt     = r_div_cnt;
    w_div_done_nxt    = r_div_done;
    w_div_start_nxt   = 1'b0;
    w_div_timeout_nxt = r_div_timeout;

    if (mem_wait) begin
      // Frozen pipeline, but a divider result must not be lost.
      if (w_div_wait && div_ready) begin
        w_div_done_nxt = 1'b1;
      end
    end else begin
      case (w_state_eff)
        ST_IDLE: begin
          if (ex_div_req) begin
            w_state_nxt     = ST_DIV_WAIT;
            w_div_cnt_nxt   = '0;
            w_div_done_nxt  = 1'b0;
            w_div_start_nxt = 1'b1;
          end else if (stallreq_for_load) begin
            w_state_nxt = ST_LOAD_BUBBLE;
          end
        end
        ST_LOAD_BUBBLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_DIV_WAIT: begin
          if (w_div_release) begin
            w_state_nxt    = ST_IDLE;
            w_div_done_nxt = 1'b0;
            if (w_div_expire) begin
              w_div_timeout_nxt = 1'b1;
            end
          end else begin
            w_div_cnt_nxt = r_div_cnt + c_DIV_CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign stall       = w_stall;
  assign div_start   = r_div_start;
  assign div_busy    = (r_state == ST_DIV_WAIT);
  assign div_timeout = r_div_timeout;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_load_cnt;
  logic [CNT_W-1:0] r_div_stall_cnt;
  logic [CNT_W-1:0] r_mem_cnt;

  // Each stalled cycle is charged to its highest-priority cause only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_load_cnt      <= '0;
      r_div_stall_cnt <= '0;
      r_mem_cnt       <= '0;
    end else if (w_cause_mem) begin
      r_mem_cnt <= r_mem_cnt + CNT_W'(1);
    end else if (w_cause_div) begin
      r_div_stall_cnt <= r_div_stall_cnt + CNT_W'(1);
    end else if (w_cause_load) begin
      r_load_cnt <= r_load_cnt + CNT_W'(1);
    end
  end

  assign load_stall_cnt = r_load_cnt;
  assign div_stall_cnt  = r_div_stall_cnt;
  assign mem_stall_cnt  = r_mem_cnt;
`else
  assign load_stall_cnt = '0;
  assign div_stall_cnt  = '0;
  assign mem_stall_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic, two
// instances (long and short divide limit) against a cycle-level reference model.
module tb_pipe_stall_ctrl;

  localparam int c_MAX_A = 40;
  localparam int c_MAX_B = 8;
  localparam int c_CW_A  = 32;
  localparam int c_CW_B  = 8;
`ifdef PIPE_PERF_CNT_EN
  localparam bit c_PERF = 1'b1;
`else
  localparam bit c_PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic stallreq_for_load;
  logic ex_div_req;
  logic div_ready;
  logic mem_wait;

  logic [5:0]        stall_a, stall_b;
  logic              start_a, start_b, busy_a, busy_b, tmo_a, tmo_b;
  logic [c_CW_A-1:0] lc_a, dc_a, mc_a;
  logic [c_CW_B-1:0] lc_b, dc_b, mc_b;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.STALL_W(6), .CNT_W(c_CW_A), .DIV_MAX_CYC(c_MAX_A)) u_dut_a (
    .clk(clk), .rst(rst), .stallreq_for_load(stallreq_for_load),
    .ex_div_req(ex_div_req), .div_ready(div_ready), .mem_wait(mem_wait),
    .stall(stall_a), .div_start(start_a), .div_busy(busy_a), .div_timeout(tmo_a),
    .load_stall_cnt(lc_a), .div_stall_cnt(dc_a), .mem_stall_cnt(mc_a)
  );

  pipe_stall_ctrl #(.STALL_W(6), .CNT_W(c_CW_B), .DIV_MAX_CYC(c_MAX_B)) u_dut_b (
    .clk(clk), .rst(rst), .stallreq_for_load(stallreq_for_load),
    .ex_div_req(ex_div_req), .div_ready(div_ready), .mem_wait(mem_wait),
    .stall(stall_b), .div_start(start_b), .div_busy(busy_b), .div_timeout(tmo_b),
    .load_stall_cnt(lc_b), .div_stall_cnt(dc_b), .mem_stall_cnt(mc_b)
  );

  typedef struct {
    bit          in_div;
    bit          bubble;
    bit          latched;
    bit          tmo;
    bit          start;
    int          elapsed;
    logic [63:0] lc;
    logic [63:0] dc;
    logic [63:0] mc;
  } mdl_t;

  mdl_t ma, mb;
  int   tests = 0;
  int   fails = 0;

  function automatic logic [5:0] f_stall(mdl_t m, int maxc);
    bit idle, rel;
    if (!rst) begin
      m.in_div = 1'b0;
      m.bubble = 1'b0;
    end
    idle = !m.in_div && !m.bubble;
    rel  = m.in_div && (div_ready || m.latched || (m.elapsed == maxc - 1));
    if (mem_wait) return 6'b011111;
    if (m.in_div && !rel) return 6'b001111;
    if (idle && ex_div_req) return 6'b001111;
    if (idle && stallreq_for_load) return 6'b000111;
    return 6'b000000;
  endfunction

  function automatic mdl_t f_next(mdl_t m, int maxc);
    logic [5:0] s;
    bit         hit;
    mdl_t       z;
    z = '{default: 0};
    s = f_stall(m, maxc);
    if (!rst) return z;
    m.start = 1'b0;
    if (c_PERF) begin
      if (mem_wait) m.mc++;
      else if (s == 6'b001111) m.dc++;
      else if (s == 6'b000111) m.lc++;
    end
    hit = div_ready || m.latched;
    if (mem_wait) begin
      if (m.in_div && div_ready) m.latched = 1'b1;
    end else if (m.bubble) begin
      m.bubble = 1'b0;
    end else if (m.in_div) begin
      if (hit || (m.elapsed == maxc - 1)) begin
        if (!hit) m.tmo = 1'b1;
        m.in_div  = 1'b0;
        m.latched = 1'b0;
      end else begin
        m.elapsed++;
      end
    end else if (ex_div_req) begin
      m.in_div  = 1'b1;
      m.elapsed = 0;
      m.latched = 1'b0;
      m.start   = 1'b1;
    end else if (stallreq_for_load) begin
      m.bubble = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [63:0] f_mask(int cw);
    return (64'd1 << cw) - 64'd1;
  endfunction

  task automatic cmp_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic cmp_s(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %06b expected %06b", tag, obs, exp);
    end
  endtask

  task automatic cmp_w(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    cmp_s("a_stall", stall_a, f_stall(ma, c_MAX_A));
    cmp_b("a_start", start_a, ma.start);
    cmp_b("a_busy",  busy_a,  ma.in_div);
    cmp_b("a_tmo",   tmo_a,   ma.tmo);
    cmp_w("a_lcnt",  64'(lc_a), ma.lc & f_mask(c_CW_A));
    cmp_w("a_dcnt",  64'(dc_a), ma.dc & f_mask(c_CW_A));
    cmp_w("a_mcnt",  64'(mc_a), ma.mc & f_mask(c_CW_A));
    cmp_s("b_stall", stall_b, f_stall(mb, c_MAX_B));
    cmp_b("b_start", start_b, mb.start);
    cmp_b("b_busy",  busy_b,  mb.in_div);
    cmp_b("b_tmo",   tmo_b,   mb.tmo);
    cmp_w("b_lcnt",  64'(lc_b), mb.lc & f_mask(c_CW_B));
    cmp_w("b_dcnt",  64'(dc_b), mb.dc & f_mask(c_CW_B));
    cmp_w("b_mcnt",  64'(mc_b), mb.mc & f_mask(c_CW_B));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input bit r, input bit ld, input bit dq, input bit dr, input bit mw);
    rst = r; stallreq_for_load = ld; ex_div_req = dq; div_ready = dr; mem_wait = mw;
    #1;
    check_model();
  endtask

  task automatic adv();
    ma = f_next(ma, c_MAX_A);
    mb = f_next(mb, c_MAX_B);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stallreq_for_load = 1'b0; ex_div_req = 1'b0; div_ready = 1'b0; mem_wait = 1'b0;
    repeat (2) @(negedge clk);
    ma = '{default: 0};
    mb = '{default: 0};

    // reset state and combinational stall during reset
    drive(0, 0, 0, 0, 0);
    cmp_s("rst_stall", stall_a, 6'b000000);
    cmp_b("rst_busy", busy_a, 1'b0);
    cmp_b("rst_start", start_a, 1'b0);
    cmp_b("rst_tmo", tmo_b, 1'b0);
    cmp_w("rst_dcnt", 64'(dc_a), 64'd0);
    adv();
    drive(0, 1, 0, 0, 0);
    cmp_s("rst_comb_load", stall_a, 6'b000111);
    adv();

    // load-use: one bubble only
    drive(1, 1, 0, 0, 0); cmp_s("load_c1", stall_a, 6'b000111); adv();
    drive(1, 1, 0, 0, 0); cmp_s("load_c2", stall_a, 6'b000000); adv();
    drive(1, 0, 0, 0, 0); cmp_w("load_cnt", 64'(lc_a), c_PERF ? 64'd1 : 64'd0); adv();

    // timeout on the 8-cycle instance; long instance keeps waiting
    drive(1, 0, 1, 0, 0); cmp_s("to_c0", stall_b, 6'b001111); adv();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 0, 0, 0);
      if (i == 1) cmp_b("to_start", start_b, 1'b1);
      cmp_s("to_stall", stall_b, (i < 8) ? 6'b001111 : 6'b000000);
      cmp_b("to_flag_pre", tmo_b, 1'b0);
      adv();
    end
    drive(1, 0, 0, 0, 0);
    cmp_b("to_flag", tmo_b, 1'b1);
    cmp_b("to_busy", busy_b, 1'b0);
    cmp_s("to_a_hold", stall_a, 6'b001111);
    adv();
    drive(1, 0, 0, 1, 0); cmp_s("to_a_release", stall_a, 6'b000000); adv();

    // divide with ready 10 cycles after the request
    drive(1, 0, 1, 0, 0);
    cmp_s("div_c0", stall_a, 6'b001111);
    cmp_b("div_c0_start", start_a, 1'b0);
    adv();
    for (int i = 1; i <= 9; i++) begin
      drive(1, 0, 1, 0, 0);
      cmp_s("div_stall", stall_a, 6'b001111);
      cmp_b("div_start", start_a, i == 1);
      cmp_b("div_busy", busy_a, 1'b1);
      adv();
    end
    drive(1, 0, 1, 1, 0); cmp_s("div_release", stall_a, 6'b000000); adv();
    drive(1, 0, 0, 0, 0);
    cmp_b("div_busy_fall", busy_a, 1'b0);
    // 10 from the timeout scenario plus 10 here
    cmp_w("div_cnt", 64'(dc_a), c_PERF ? 64'd20 : 64'd0);
    adv();

    // divide result arrives under a 3-cycle memory wait
    drive(1, 0, 1, 0, 0); adv();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0, 0, 0); cmp_s("dm_wait", stall_a, 6'b001111); adv();
    end
    drive(1, 0, 0, 1, 1); cmp_s("dm_mem0", stall_a, 6'b011111); adv();
    drive(1, 0, 0, 0, 1); cmp_s("dm_mem1", stall_a, 6'b011111); adv();
    drive(1, 0, 0, 0, 1); cmp_s("dm_mem2", stall_a, 6'b011111); adv();
    drive(1, 0, 0, 0, 0);
    cmp_s("dm_release", stall_a, 6'b000000);
    cmp_b("dm_busy", busy_a, 1'b1);
    adv();
    drive(1, 0, 0, 0, 0);
    cmp_b("dm_idle", busy_a, 1'b0);
    cmp_w("dm_mcnt", 64'(mc_a), c_PERF ? 64'd3 : 64'd0);
    adv();

    // reset in DIV_WAIT cycle 4
    drive(1, 0, 1, 0, 0); cmp_b("to_sticky", tmo_b, 1'b1); adv();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0, 0, 0); adv();
    end
    drive(0, 0, 0, 0, 0); cmp_s("mr_stall_in_rst", stall_a, 6'b000000); adv();
    drive(1, 0, 0, 0, 0);
    cmp_b("mr_busy", busy_a, 1'b0);
    cmp_b("mr_start", start_a, 1'b0);
    cmp_s("mr_stall", stall_a, 6'b000000);
    cmp_w("mr_dcnt", 64'(dc_a), 64'd0);
    cmp_b("mr_tmo", tmo_b, 1'b0);
    adv();

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 99) >= 2,
            $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 25);
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
